// File: rtl/bicubic_mac4_pipe_if.sv
// Handshake bundle for the 4-tap bicubic MAC pipeline: tap-row input side and result output side.
interface bicubic_mac4_pipe_if #(
  parameter int PIXEL_W = 8,
  parameter int CH      = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [11:0]               in_wcode;
  logic [3:0]                in_wsign;
  logic [CH*4*PIXEL_W-1:0]   in_pixel;
  logic                      out_valid;
  logic                      out_ready;
  logic [CH*PIXEL_W-1:0]     out_pixel;
  logic [CH-1:0]             out_sat;

  modport master (
    output in_valid, in_wcode, in_wsign, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_sat
  );

  modport slave (
    input  in_valid, in_wcode, in_wsign, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_sat
  );
endinterface

// File: rtl/bicubic_mac4_pipe.sv
// 3-stage 4-tap bicubic multiply-accumulate: exact shift-add products, signed tap sum,
// then round/shift/clamp to an unsigned pixel per channel, with valid/ready on both sides.
module bicubic_mac4_pipe #(
  parameter int PIXEL_W  = 8,
  parameter int CH       = 3,
  parameter bit ROUND_EN = 1'b1
) (
  input logic                clk,
  input logic                rst,
  bicubic_mac4_pipe_if.slave bus
);
  localparam int PROD_W = PIXEL_W + 8;
  localparam int SUM_W  = PIXEL_W + 11;
  localparam int SHR_W  = SUM_W - 7;
  localparam logic [SUM_W-1:0]   RND_ADD = SUM_W'(ROUND_EN ? 64 : 0);
  localparam logic [PIXEL_W-1:0] PIX_MAX = '1;

  // Weight is x/128; each code expands to a fixed shift-add network.
  function automatic logic [PROD_W-1:0] wmul(input logic [PIXEL_W-1:0] pix,
                                             input logic [2:0]         code);
    logic [PROD_W-1:0] p;
    p = PROD_W'(pix);
    case (code)
      3'd0:    wmul = '0;
      3'd1:    wmul = (p << 1) + p;
      3'd2:    wmul = p << 3;
      3'd3:    wmul = (p << 3) + p;
      3'd4:    wmul = (p << 4) + (p << 3) + (p << 2) + p;
      3'd5:    wmul = (p << 6) + (p << 3);
      3'd6:    wmul = (p << 7) - (p << 4) - p;
      default: wmul = p << 7;
    endcase
  endfunction

  logic v_p_q, v_p_d;
  logic v_s_q, v_s_d;
  logic v_r_q, v_r_d;
  logic rdy_p, rdy_s, rdy_r;
  logic ld_p, ld_s, ld_r;

  logic [PROD_W-1:0]     prod_q [CH][4];
  logic [PROD_W-1:0]     prod_d [CH][4];
  logic [3:0]            neg_q  [CH];
  logic [3:0]            neg_d  [CH];
  logic [SUM_W-1:0]      sum_q  [CH];
  logic [SUM_W-1:0]      sum_d  [CH];
  logic [CH*PIXEL_W-1:0] out_pixel_q, out_pixel_d;
  logic [CH-1:0]         out_sat_q, out_sat_d;

  // A stage may load when empty or when the stage after it is taking its content.
  always_comb begin
    rdy_r = ~v_r_q | bus.out_ready;
    rdy_s = ~v_s_q | rdy_r;
    rdy_p = ~v_p_q | rdy_s;
    ld_p  = rdy_p & bus.in_valid;
    ld_s  = rdy_s & v_p_q;
    ld_r  = rdy_r & v_s_q;
    v_p_d = rdy_p ? bus.in_valid : v_p_q;
    v_s_d = rdy_s ? v_p_q : v_s_q;
    v_r_d = rdy_r ? v_s_q : v_r_q;
  end

  assign bus.in_ready  = rdy_p;
  assign bus.out_valid = v_r_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_sat   = out_sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_p_q <= 1'b0;
      v_s_q <= 1'b0;
      v_r_q <= 1'b0;
    end else begin
      v_p_q <= v_p_d;
      v_s_q <= v_s_d;
      v_r_q <= v_r_d;
    end
  end

  // Stage P: exact unsigned product and effective sign per channel/tap.
  always_comb begin
    logic [PIXEL_W-1:0] pix;
    logic [2:0]         code;
    for (int c = 0; c < CH; c++) begin
      neg_d[c] = neg_q[c];
      for (int k = 0; k < 4; k++) begin
        pix          = bus.in_pixel[(4*c+k)*PIXEL_W +: PIXEL_W];
        code         = bus.in_wcode[3*k +: 3];
        prod_d[c][k] = prod_q[c][k];
        if (ld_p) begin
          prod_d[c][k] = wmul(pix, code);
          neg_d[c][k]  = bus.in_wsign[k] & (code != 3'd0) & (pix != '0);
        end
      end
    end
  end

  // Stage S: two's-complement tap sum; width leaves headroom for 4 x full-scale.
  always_comb begin
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] term;
    for (int c = 0; c < CH; c++) begin
      acc = '0;
      for (int k = 0; k < 4; k++) begin
        term = SUM_W'(prod_q[c][k]);
        acc  = neg_q[c][k] ? (acc - term) : (acc + term);
      end
      sum_d[c] = ld_s ? acc : sum_q[c];
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    neg_q  <= neg_d;
    sum_q  <= sum_d;
  end

  // Stage R: optional half-up rounding, floor shift by 7, clamp to [0, PIX_MAX].
  always_comb begin
    logic [SUM_W-1:0] rnd;
    logic [SHR_W-1:0] shr;
    out_pixel_d = out_pixel_q;
    out_sat_d   = out_sat_q;
    for (int c = 0; c < CH; c++) begin
      rnd = sum_q[c] + RND_ADD;
      shr = rnd[SUM_W-1:7];
      if (ld_r) begin
        if (shr[SHR_W-1]) begin
          out_pixel_d[c*PIXEL_W +: PIXEL_W] = '0;
          out_sat_d[c]                      = 1'b1;
        end else if (|shr[SHR_W-2:PIXEL_W]) begin
          out_pixel_d[c*PIXEL_W +: PIXEL_W] = PIX_MAX;
          out_sat_d[c]                      = 1'b1;
        end else begin
          out_pixel_d[c*PIXEL_W +: PIXEL_W] = shr[PIXEL_W-1:0];
          out_sat_d[c]                      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pixel_q <= '0;
      out_sat_q   <= '0;
    end else begin
      out_pixel_q <= out_pixel_d;
      out_sat_q   <= out_sat_d;
    end
  end
endmodule

// File: tb/tb_bicubic_mac4_pipe.sv
// Bench for bicubic_mac4_pipe: three parameterisations driven with directed and random rows,
// results compared against an integer-arithmetic model of the interpolation.
module tb_bicubic_mac4_pipe;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bicubic_mac4_pipe_if #(.PIXEL_W(8),  .CH(3)) ia ();
  bicubic_mac4_pipe_if #(.PIXEL_W(8),  .CH(4)) ib ();
  bicubic_mac4_pipe_if #(.PIXEL_W(10), .CH(1)) ic ();

  bicubic_mac4_pipe #(.PIXEL_W(8),  .CH(3), .ROUND_EN(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ia));
  bicubic_mac4_pipe #(.PIXEL_W(8),  .CH(4), .ROUND_EN(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ib));
  bicubic_mac4_pipe #(.PIXEL_W(10), .CH(1), .ROUND_EN(1'b1)) u_c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] wc;
    logic [3:0]  ws;
    logic [95:0] px;
    logic [39:0] ep;
    logic [3:0]  es;
  } row_t;

  row_t pend[$];
  row_t sb[$];
  int   n_acc;
  int   n_out;

  localparam logic [11:0] W_UNITY = {3'd1, 3'd4, 3'd6, 3'd3};
  localparam logic [3:0]  S_UNITY = 4'b1001;

  function automatic int ref_calc(input int pw, input bit rnd, input logic [11:0] wc,
                                  input logic [3:0] ws, input int p [4], output bit sat);
    int wt [8];
    int sum;
    int q;
    int mx;
    wt  = '{0, 3, 8, 9, 29, 72, 111, 128};
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      if (ws[k]) sum = sum - p[k] * wt[wc[3*k +: 3]];
      else       sum = sum + p[k] * wt[wc[3*k +: 3]];
    end
    if (rnd) sum = sum + 64;
    q   = sum >>> 7;
    mx  = (1 << pw) - 1;
    sat = (q < 0) || (q > mx);
    if (q < 0)  return 0;
    if (q > mx) return mx;
    return q;
  endfunction

  task automatic model(input int pw, input int ch, input bit rnd, input logic [11:0] wc,
                       input logic [3:0] ws, input logic [127:0] px,
                       output logic [39:0] ep, output logic [3:0] es);
    int p [4];
    int r;
    bit s;
    logic [127:0] mask;
    mask = (128'd1 << pw) - 128'd1;
    ep   = '0;
    es   = '0;
    for (int c = 0; c < ch; c++) begin
      for (int k = 0; k < 4; k++) p[k] = int'((px >> ((4*c+k)*pw)) & mask);
      r     = ref_calc(pw, rnd, wc, ws, p, s);
      ep    = ep | (40'(r) << (c*pw));
      es[c] = s;
    end
  endtask

  task automatic chk(input logic [39:0] obs, input logic [39:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_a(input logic [11:0] wc, input logic [3:0] ws, input logic [95:0] px);
    row_t r;
    r.wc = wc;
    r.ws = ws;
    r.px = px;
    model(8, 3, 1'b1, wc, ws, 128'(px), r.ep, r.es);
    pend.push_back(r);
  endtask

  function automatic logic [95:0] rep_a(input logic [7:0] p0, input logic [7:0] p1,
                                        input logic [7:0] p2, input logic [7:0] p3);
    logic [31:0] row;
    row = {p3, p2, p1, p0};
    return {row, row, row};
  endfunction

  // One cycle on instance A: drive from pending queue, check the output against the
  // in-order scoreboard head, record transfers, then advance to the next falling edge.
  task automatic step_a(input bit vld, input bit ordy);
    ia.out_ready = ordy;
    ia.in_valid  = vld && (pend.size() > 0);
    if (pend.size() > 0) begin
      ia.in_wcode = pend[0].wc;
      ia.in_wsign = pend[0].ws;
      ia.in_pixel = pend[0].px;
    end
    #2;
    if (ia.out_valid === 1'b1) begin
      chk(40'(sb.size() > 0), 40'd1, "a_unexpected_result");
      if (sb.size() > 0) begin
        chk(40'(ia.out_pixel), sb[0].ep, "a_pixel");
        chk(40'(ia.out_sat), 40'(sb[0].es), "a_sat");
        if (ordy) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
    if (ia.in_valid && ia.in_ready === 1'b1) begin
      sb.push_back(pend.pop_front());
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 60 && (sb.size() > 0 || pend.size() > 0); i++) step_a(1'b1, 1'b1);
    chk(40'(sb.size() + pend.size()), 40'd0, "a_drain");
  endtask

  task automatic latency_a(input string tag);
    step_a(1'b1, 1'b1);
    #1 chk(40'(ia.out_valid), 40'd0, {tag, "_edge1"});
    step_a(1'b0, 1'b1);
    #1 chk(40'(ia.out_valid), 40'd0, {tag, "_edge2"});
    step_a(1'b0, 1'b1);
    #1 chk(40'(ia.out_valid), 40'd1, {tag, "_edge3"});
    step_a(1'b0, 1'b1);
  endtask

  task automatic run_b(input logic [11:0] wc, input logic [3:0] ws, input logic [127:0] px,
                       input string tag);
    logic [39:0] ep;
    logic [3:0]  es;
    model(8, 4, 1'b0, wc, ws, px, ep, es);
    ib.in_wcode = wc; ib.in_wsign = ws; ib.in_pixel = px;
    ib.in_valid = 1'b1; ib.out_ready = 1'b1;
    #1 chk(40'(ib.in_ready), 40'd1, {tag, "_ready"});
    @(posedge clk); @(negedge clk);
    ib.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    chk(40'(ib.out_valid), 40'd1, {tag, "_valid"});
    chk(40'(ib.out_pixel), ep, {tag, "_pixel"});
    chk(40'(ib.out_sat), 40'(es), {tag, "_sat"});
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_c(input logic [11:0] wc, input logic [3:0] ws, input logic [39:0] px,
                       input string tag);
    logic [39:0] ep;
    logic [3:0]  es;
    model(10, 1, 1'b1, wc, ws, 128'(px), ep, es);
    ic.in_wcode = wc; ic.in_wsign = ws; ic.in_pixel = px;
    ic.in_valid = 1'b1; ic.out_ready = 1'b1;
    #1 chk(40'(ic.in_ready), 40'd1, {tag, "_ready"});
    @(posedge clk); @(negedge clk);
    ic.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    chk(40'(ic.out_valid), 40'd1, {tag, "_valid"});
    chk(40'(ic.out_pixel), ep, {tag, "_pixel"});
    chk(40'(ic.out_sat), 40'(es), {tag, "_sat"});
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [127:0] pxb;
    logic [95:0]  pxa;
    n_tests = 0; n_fail = 0; n_acc = 0; n_out = 0;
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.out_ready = 1'b1; ia.in_wcode = '0; ia.in_wsign = '0; ia.in_pixel = '0;
    ib.in_valid = 1'b0; ib.out_ready = 1'b1; ib.in_wcode = '0; ib.in_wsign = '0; ib.in_pixel = '0;
    ic.in_valid = 1'b0; ic.out_ready = 1'b1; ic.in_wcode = '0; ic.in_wsign = '0; ic.in_pixel = '0;

    #3;
    chk(40'(ia.out_valid), 40'd0, "rst_out_valid");
    chk(40'(ia.out_pixel), 40'd0, "rst_out_pixel");
    chk(40'(ia.out_sat), 40'd0, "rst_out_sat");
    chk(40'(ia.in_ready), 40'd1, "rst_in_ready");
    @(negedge clk);
    rst = 1'b0;
    #1 chk(40'(ia.in_ready), 40'd1, "post_rst_in_ready");

    add_a(W_UNITY, S_UNITY, rep_a(8'd200, 8'd200, 8'd200, 8'd200));
    latency_a("unity_latency");
    chk(40'(n_out), 40'd1, "unity_delivered");

    add_a(W_UNITY, S_UNITY, rep_a(8'd0, 8'd255, 8'd255, 8'd0));
    add_a(W_UNITY, S_UNITY, rep_a(8'd255, 8'd0, 8'd0, 8'd255));
    add_a(12'h028, 4'h0, rep_a(8'd0, 8'd1, 8'd0, 8'd0));
    add_a(12'h007, 4'h1, rep_a(8'd0, 8'd0, 8'd0, 8'd0));
    add_a(W_UNITY, S_UNITY, {32'h0A0A0A0A, 32'h64646464, 32'h0F0F0F0F});
    drain_a();

    // Stall the output for 6 cycles with 10 rows offered, then release.
    for (int i = 0; i < 10; i++) add_a($urandom, $urandom, {$urandom, $urandom, $urandom});
    n_acc = 0;
    for (int i = 0; i < 6; i++) step_a(1'b1, 1'b0);
    chk(40'(n_acc), 40'd3, "bp_accepted_while_stalled");
    chk(40'(ia.in_ready), 40'd0, "bp_in_ready_low");
    n_out = 0;
    for (int i = 0; i < 10; i++) step_a(1'b1, 1'b1);
    chk(40'(n_out), 40'd10, "bp_release_one_per_cycle");
    chk(40'(sb.size() + pend.size()), 40'd0, "bp_all_delivered");

    for (int i = 0; i < 40; i++) begin
      pxa = {$urandom, $urandom, $urandom};
      add_a($urandom, $urandom, pxa);
    end
    for (int i = 0; i < 2000 && (sb.size() > 0 || pend.size() > 0); i++)
      step_a($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    chk(40'(sb.size() + pend.size()), 40'd0, "random_all_delivered");

    // Reset with a full pipe, asserted between edges.
    for (int i = 0; i < 3; i++) add_a(W_UNITY, S_UNITY, rep_a(8'd90, 8'd90, 8'd90, 8'd90));
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0);
    chk(40'(ia.out_valid), 40'd1, "pre_rst_full");
    #1 rst = 1'b1;
    #1;
    chk(40'(ia.out_valid), 40'd0, "midrst_out_valid");
    chk(40'(ia.out_pixel), 40'd0, "midrst_out_pixel");
    chk(40'(ia.out_sat), 40'd0, "midrst_out_sat");
    chk(40'(ia.in_ready), 40'd1, "midrst_in_ready");
    sb.delete();
    pend.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1);
    add_a(W_UNITY, S_UNITY, rep_a(8'd42, 8'd42, 8'd42, 8'd42));
    latency_a("post_rst_latency");
    drain_a();

    pxb = '0;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) pxb[(4*c+k)*8 +: 8] = 8'(20 + 60*c);
    run_b(W_UNITY, S_UNITY, pxb, "b_per_channel");
    pxb = '0;
    for (int c = 0; c < 4; c++) pxb[(4*c+1)*8 +: 8] = 8'd1;
    run_b(12'h028, 4'h0, pxb, "b_truncate");
    run_b($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom}, "b_random");

    run_c(12'h1C0, 4'h0, {10'd77, 10'd1023, 10'd512, 10'd3}, "c_full_scale");
    run_c(W_UNITY, S_UNITY, {10'd0, 10'd1023, 10'd1023, 10'd0}, "c_overflow");
    run_c($urandom, $urandom, 40'({$urandom, $urandom}), "c_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
